// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts word-aligned fetch requests, reads an
// internal instruction array through a fixed-latency pipeline and returns the
// results in acceptance order from a credit-limited response FIFO. A flush
// discards all outstanding work; a backdoor port preloads the array.
module imem_responder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_WORDS  = 256,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic [ADDR_W-1:0]            req_addr_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [DATA_W-1:0]            rsp_data_o,
    output logic [ADDR_W-1:0]            rsp_addr_o,
    output logic                         rsp_err_o,
    input  logic                         flush_i,
    input  logic                         load_en_i,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
    input  logic [DATA_W-1:0]            load_data_i
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;

    // Instruction array (never cleared by reset or flush)
    logic [DATA_W-1:0] mem_r [MEM_WORDS];

    // Read pipeline: valid, data, echoed address, error per stage
    logic [LATENCY-1:0] pv_r;
    logic [DATA_W-1:0]  pd_r [LATENCY];
    logic [ADDR_W-1:0]  pa_r [LATENCY];
    logic [LATENCY-1:0] pe_r;

    // Response FIFO
    logic [DATA_W-1:0]     fd_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]     fa_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fe_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      cnt_r;

    logic [OCC_W-1:0] occ_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_ne_s;
    logic             req_oor_s;
    logic [IDX_W-1:0] req_idx_s;
    logic             unused_s;

    // Byte-offset bits of the request address carry no information
    assign unused_s = ^req_addr_i[1:0];

    // Word index and range check: any set bit above the array index is out of range
    assign req_idx_s = req_addr_i[IDX_W+1:2];
    assign req_oor_s = |req_addr_i[ADDR_W-1:IDX_W+2];

    // Occupancy = live pipeline stages plus buffered responses (credit count)
    always_comb begin
        occ_s = OCC_W'(cnt_r);
        for (int i = 0; i < LATENCY; i++) begin
            occ_s = occ_s + OCC_W'(pv_r[i]);
        end
    end

    // Credit is taken from pre-edge occupancy, so a same-cycle pop never frees a slot early
    assign req_ready_o = ~flush_i & (occ_s < OCC_W'(FIFO_DEPTH));
    assign accept_s    = req_valid_i & req_ready_o;
    assign fifo_ne_s   = (cnt_r != {CNT_W{1'b0}});
    assign rsp_valid_o = ~flush_i & fifo_ne_s;
    assign pop_s       = rsp_valid_o & rsp_ready_i;
    // Pipeline exit always has a reserved FIFO slot
    assign push_s      = pv_r[LATENCY-1];

    // Backdoor load; read-first with respect to a same-edge accept
    always_ff @(posedge clk) begin
        if (!srst && load_en_i) begin
            mem_r[load_addr_i] <= load_data_i;
        end
    end

    // Pipeline valid bits: cleared by reset and flush, otherwise shift one stage per cycle
    always_ff @(posedge clk) begin
        if (srst) begin
            pv_r <= {LATENCY{1'b0}};
        end else if (flush_i) begin
            pv_r <= {LATENCY{1'b0}};
        end else begin
            pv_r[0] <= accept_s;
            for (int i = 1; i < LATENCY; i++) begin
                pv_r[i] <= pv_r[i-1];
            end
        end
    end

    // Pipeline payload: qualified by the valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        pd_r[0] <= req_oor_s ? {DATA_W{1'b0}} : mem_r[req_idx_s];
        pa_r[0] <= {req_addr_i[ADDR_W-1:2], 2'b00};
        pe_r[0] <= req_oor_s;
        for (int i = 1; i < LATENCY; i++) begin
            pd_r[i] <= pd_r[i-1];
            pa_r[i] <= pa_r[i-1];
            pe_r[i] <= pe_r[i-1];
        end
    end

    // Response FIFO pointers/count; reset and flush empty it
    always_ff @(posedge clk) begin
        if (srst || flush_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Response FIFO storage: written at the pipeline exit
    always_ff @(posedge clk) begin
        if (push_s) begin
            fd_r[wr_ptr_r] <= pd_r[LATENCY-1];
            fa_r[wr_ptr_r] <= pa_r[LATENCY-1];
            fe_r[wr_ptr_r] <= pe_r[LATENCY-1];
        end
    end

    // Head of FIFO drives the response; zero when nothing is buffered
    always_comb begin
        if (fifo_ne_s) begin
            rsp_data_o = fd_r[rd_ptr_r];
            rsp_addr_o = fa_r[rd_ptr_r];
            rsp_err_o  = fe_r[rd_ptr_r];
        end else begin
            rsp_data_o = {DATA_W{1'b0}};
            rsp_addr_o = {ADDR_W{1'b0}};
            rsp_err_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized
// traffic, compared cycle by cycle against a transaction-level reference model.
module tb_imem_responder;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_WORDS  = 256;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              srst;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic [ADDR_W-1:0] rsp_addr_o;
    logic              rsp_err_o;
    logic              flush_i;
    logic              load_en_i;
    logic [7:0]        load_addr_i;
    logic [DATA_W-1:0] load_data_i;

    imem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS),
        .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .srst(srst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_addr_o(rsp_addr_o), .rsp_err_o(rsp_err_o),
        .flush_i(flush_i), .load_en_i(load_en_i),
        .load_addr_i(load_addr_i), .load_data_i(load_data_i)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding responses in acceptance order, each with the
    // edge count after which it becomes visible if it is at the head.
    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
        int          avail;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem_m [MEM_WORDS];
    int          n_edge   = 0;
    bit          armed    = 1'b0;
    bit          prev_rst = 1'b0;
    int          n_vec    = 0;
    int          n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h (edge %0d)", tag, obs, exp, n_edge);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic rst, input logic rv, input logic [31:0] ra,
                        input logic rr, input logic fl, input logic le,
                        input logic [7:0] la, input logic [31:0] ld, output logic acc);
        logic  exp_ready;
        logic  exp_valid;
        rsp_t  e;
        logic [29:0] idx;
        @(negedge clk);
        srst = rst; req_valid_i = rv; req_addr_i = ra; rsp_ready_i = rr;
        flush_i = fl; load_en_i = le; load_addr_i = la; load_data_i = ld;
        #1;
        exp_ready = !fl && (q.size() < FIFO_DEPTH);
        exp_valid = !fl && (q.size() > 0) && (q[0].avail <= n_edge);
        if (armed) begin
            check("req_ready", {31'd0, req_ready_o}, {31'd0, exp_ready});
            check("rsp_valid", {31'd0, rsp_valid_o}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("rsp_data", rsp_data_o, q[0].data);
                check("rsp_addr", rsp_addr_o, q[0].addr);
                check("rsp_err", {31'd0, rsp_err_o}, {31'd0, q[0].err});
            end
            if (prev_rst) begin
                check("rst_data", rsp_data_o, 32'd0);
                check("rst_addr", rsp_addr_o, 32'd0);
                check("rst_err", {31'd0, rsp_err_o}, 32'd0);
            end
        end
        acc = rv && exp_ready && !rst;
        if (rst || fl) begin
            q.delete();
        end else begin
            if (exp_valid && rr) void'(q.pop_front());
            if (acc) begin
                idx     = ra[31:2];
                e.addr  = ra & 32'hFFFF_FFFC;
                e.err   = (idx >= 30'(MEM_WORDS));
                e.data  = e.err ? 32'd0 : mem_m[idx[7:0]];
                e.avail = n_edge + 1 + LATENCY;
                q.push_back(e);
            end
        end
        if (!rst && le) mem_m[la] = ld;
        n_edge++;
        prev_rst = rst;
        if (rst) armed = 1'b1;
        @(posedge clk);
    endtask

    task automatic idle(input logic rr);
        logic acc;
        step(1'b0, 1'b0, 32'd0, rr, 1'b0, 1'b0, 8'd0, 32'd0, acc);
    endtask

    task automatic drain();
        int cyc = 0;
        while (q.size() > 0 && cyc < 60) begin
            idle(1'b1);
            cyc++;
        end
        check("drain_left", q.size(), 32'd0);
        idle(1'b1);
    endtask

    // Issue nreq sequential word requests; rsp_ready_i held low for the first 'hold' cycles.
    task automatic issue_seq(input int nreq, input logic [31:0] base, input int hold);
        int   k   = 0;
        int   cyc = 0;
        logic acc;
        while (k < nreq && cyc < 200) begin
            step(1'b0, 1'b1, base + 32'(4 * k), (cyc >= hold), 1'b0, 1'b0, 8'd0, 32'd0, acc);
            if (acc) k++;
            cyc++;
        end
        check("issue_count", k, nreq);
        drain();
    endtask

    initial begin
        logic acc;
        srst = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'd0; rsp_ready_i = 1'b0;
        flush_i = 1'b0; load_en_i = 1'b0; load_addr_i = 8'd0; load_data_i = 32'd0;

        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);

        // Preload whole array (words 0..7 with the recognisable pattern)
        for (int i = 0; i < MEM_WORDS; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 8'(i),
                 (i < 8) ? (32'h1000_0000 + 32'(i)) : $urandom(), acc);
        end

        // Back-to-back streaming
        issue_seq(8, 32'h0000_0000, 0);
        // Backpressure: 4 accepted, then stall until responses pop
        issue_seq(6, 32'h0000_0020, 8);
        // Out-of-range address
        issue_seq(1, 32'h0000_0400, 0);

        // Flush with 1 buffered and 2 in the pipeline
        step(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        check("flush_acc0", {31'd0, acc}, 32'd1);
        step(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        step(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0, acc);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        issue_seq(1, 32'h0000_0008, 0);

        // Load colliding with an accept to the same word: old data first
        step(1'b0, 1'b1, 32'h0000_0014, 1'b1, 1'b0, 1'b1, 8'd5, 32'hDEAD_BEEF, acc);
        check("load_acc", {31'd0, acc}, 32'd1);
        drain();
        issue_seq(1, 32'h0000_0014, 0);

        // Reset with outstanding work; coincident load must be ignored
        step(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        step(1'b0, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        step(1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, acc);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 8'd0, 32'hBAD0_BAD0, acc);
        idle(1'b0);
        issue_seq(3, 32'h0000_0000, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ra;
            if ($urandom_range(0, 9) == 0) ra = $urandom();
            else ra = {20'd0, 10'($urandom_range(0, 299)), 2'($urandom())};
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), ra,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) == 0), 8'($urandom()), $urandom(), acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
